cci_mpf_c0tx_buffer: RTL

//   Elastic buffer on the MPF channel 0 (read request) TX path, placed between
//   the AFU side of a cci_mpf_if and the next stage toward the FIU.

---
 rtl/cci_mpf_c0tx_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/cci_mpf_c0tx_buffer.sv
// Elastic FIFO on the MPF channel 0 TX path between the AFU and the FIU side.
// It absorbs requests issued after almost-full and forwards them in order.
module cci_mpf_c0tx_buffer #(
  parameter int N_ENTRIES     = 16,
  parameter int REQ_WIDTH     = 128,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REQ_WIDTH-1:0]         afu_req,
  input  logic                         afu_req_valid,
  output logic                         afu_almfull,
  output logic [REQ_WIDTH-1:0]         fiu_req,
  output logic                         fiu_req_valid,
  input  logic                         fiu_almfull,
  output logic [$clog2(N_ENTRIES):0]   occupancy,
  output logic                         overflow_err
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(N_ENTRIES);
  localparam logic [CW-1:0] ALM_TH = CW'(N_ENTRIES - ALMFULL_SLACK);

  logic [REQ_WIDTH-1:0] mem_q [N_ENTRIES];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [REQ_WIDTH-1:0] fiu_req_q, fiu_req_d;
  logic                 fiu_req_valid_q, fiu_req_valid_d;
  logic                 afu_almfull_q, afu_almfull_d;
  logic                 overflow_err_q, overflow_err_d;

  logic pop;
  logic push;
  logic drop;

  always_comb begin
    pop  = (count_q != '0) && !fiu_almfull;
    push = afu_req_valid && ((count_q != FULL) || pop);
    drop = afu_req_valid && (count_q == FULL) && !pop;
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    fiu_req_d       = fiu_req_q;
    fiu_req_valid_d = pop;
    overflow_err_d  = overflow_err_q || drop;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      fiu_req_d = mem_q[rd_ptr_q];
    end
    // Push and pop together leave the count unchanged.
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    afu_almfull_d = (count_d >= ALM_TH);
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= afu_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      fiu_req_q       <= '0;
      fiu_req_valid_q <= 1'b0;
      afu_almfull_q   <= 1'b1;
      overflow_err_q  <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      fiu_req_q       <= fiu_req_d;
      fiu_req_valid_q <= fiu_req_valid_d;
      afu_almfull_q   <= afu_almfull_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign afu_almfull   = afu_almfull_q;
  assign fiu_req       = fiu_req_q;
  assign fiu_req_valid = fiu_req_valid_q;
  assign occupancy     = count_q;
  assign overflow_err  = overflow_err_q;

endmodule
